// File: rtl/rls_drv_pkg.sv
// Shared types and sizing for the RLS estimator host driver.
// State encoding for the driver FSM and the word-index width used by the
// estimate collector live here so both files agree on them.
package rls_drv_pkg;

   // Driver FSM states, one per phase of an estimator iteration.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_LOAD = 3'd2,
      COLLECT   = 3'd3,
      HOLD      = 3'd4,
      DONE      = 3'd5
   } drv_state_e;

   // Default vector length and word width of the estimator.
   localparam int unsigned RLS_N     = 2;
   localparam int unsigned RLS_NBITS = 32;

   // Width of a word index into an N-word vector (at least one bit).
   localparam int unsigned RLS_IDX_W = (RLS_N > 1) ? $clog2(RLS_N) : 1;

   // Word-index width for an arbitrary vector length.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rls_x_collector.sv
// Reassembles the serially written estimate words into one parallel vector.
// The first captured word lands in the least significant slice. full_o is
// raised combinationally on the capture that completes the vector, so the
// driver can present the estimate on the very next cycle.
module rls_x_collector
   import rls_drv_pkg::*;
#(
   parameter int unsigned N     = RLS_N,
   parameter int unsigned nBits = RLS_NBITS,
   parameter int unsigned IDX_W = RLS_IDX_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_i,
   input  logic                 capture_i,
   input  logic [nBits-1:0]     x_i,
   output logic [N*nBits-1:0]   est_x_o,
   output logic                 full_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   logic [IDX_W-1:0]   cnt_q;
   logic [N*nBits-1:0] est_x_q;

   // Word counter and slice-addressed estimate register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= {IDX_W{1'b0}};
         est_x_q <= {(N*nBits){1'b0}};
      end else if (clear_i) begin
         cnt_q   <= {IDX_W{1'b0}};
         est_x_q <= {(N*nBits){1'b0}};
      end else if (capture_i) begin
         for (int k = 0; k < N; k++) begin
            if (cnt_q == IDX_W'(k)) begin
               est_x_q[k*nBits +: nBits] <= x_i;
            end
         end
         cnt_q <= (cnt_q == LAST_IDX) ? {IDX_W{1'b0}} : (cnt_q + IDX_W'(1));
      end else begin
         cnt_q   <= cnt_q;
         est_x_q <= est_x_q;
      end
   end

   assign full_o  = capture_i & (cnt_q == LAST_IDX);
   assign est_x_o = est_x_q;

endmodule

// File: rtl/rls_driver.sv
// Host-side driver for the RLS estimator datapath.
// Takes one sample per iteration over a valid/ready handshake, presents it on
// the core's parallel operand inputs, pulses newIt, follows the core's
// load/write strobes and hands the reassembled estimate to the consumer.
// Optional watchdog: define RLS_DRV_WDOG_EN to abort an iteration whose core
// stays silent for TIMEOUT cycles while waiting for load or for x words.
// The core's last-iteration flag is the port final_i.
module rls_driver
   import rls_drv_pkg::*;
#(
   parameter int unsigned N       = RLS_N,
   parameter int unsigned nBits   = RLS_NBITS,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [nBits-1:0]     in_y,
   input  logic [N*nBits-1:0]   in_A,
   input  logic [N*nBits-1:0]   in_Ks,
   output logic                 newIt,
   output logic [nBits-1:0]     y,
   output logic [N*nBits-1:0]   wireA,
   output logic [N*nBits-1:0]   wireKs,
   input  logic                 load,
   input  logic                 write,
   input  logic [nBits-1:0]     x,
   input  logic                 final_i,
   output logic                 est_valid,
   input  logic                 est_ready,
   output logic [N*nBits-1:0]   est_x,
   output logic [31:0]          est_count,
   output logic                 done,
   output logic                 wdog_err
);

   drv_state_e         state_q;
   logic               in_ready_q;
   logic               new_it_q;
   logic [nBits-1:0]   y_q;
   logic [N*nBits-1:0] wire_a_q;
   logic [N*nBits-1:0] wire_ks_q;
   logic               est_valid_q;
   logic [31:0]        est_count_q;
   logic               done_q;
   logic               final_q;

   logic               accept_s;
   logic               capture_s;
   logic               full_s;
   logic               final_seen_s;
   logic               wdog_trip_s;

   assign accept_s     = (state_q == IDLE) & in_valid & in_ready_q;
   assign capture_s    = (state_q == COLLECT) & write;
   assign final_seen_s = final_q | final_i;

   rls_x_collector #(
      .N     (N),
      .nBits (nBits),
      .IDX_W (idx_width(N))
   ) u_collector (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (accept_s),
      .capture_i (capture_s),
      .x_i       (x),
      .est_x_o   (est_x),
      .full_o    (full_s)
   );

`ifdef RLS_DRV_WDOG_EN
   localparam int unsigned     WDOG_W    = $clog2(TIMEOUT + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   logic [WDOG_W-1:0] wdog_cnt_q;
   logic              wdog_err_q;
   logic              wdog_run_s;

   // Count only cycles in which the core makes no progress.
   always_comb begin
      wdog_run_s  = 1'b0;
      wdog_trip_s = 1'b0;
      if (((state_q == WAIT_LOAD) && !load) || ((state_q == COLLECT) && !write)) begin
         wdog_run_s  = 1'b1;
         wdog_trip_s = (wdog_cnt_q == WDOG_LAST);
      end else begin
         wdog_run_s  = 1'b0;
         wdog_trip_s = 1'b0;
      end
   end

   // Stall counter plus sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_cnt_q <= {WDOG_W{1'b0}};
         wdog_err_q <= 1'b0;
      end else begin
         if (wdog_run_s && !wdog_trip_s) begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
         end else begin
            wdog_cnt_q <= {WDOG_W{1'b0}};
         end
         if (wdog_trip_s) begin
            wdog_err_q <= 1'b1;
         end else begin
            wdog_err_q <= wdog_err_q;
         end
      end
   end

   assign wdog_err = wdog_err_q;
`else
   assign wdog_trip_s = 1'b0;
   assign wdog_err    = 1'b0;

   // Without the watchdog the timeout value shapes no hardware.
   if (TIMEOUT == 0) begin : g_no_timeout
   end
`endif

   // Iteration FSM with its registered handshake, operand and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         new_it_q    <= 1'b0;
         y_q         <= {nBits{1'b0}};
         wire_a_q    <= {(N*nBits){1'b0}};
         wire_ks_q   <= {(N*nBits){1'b0}};
         est_valid_q <= 1'b0;
         est_count_q <= 32'd0;
         done_q      <= 1'b0;
         final_q     <= 1'b0;
      end else begin
         in_ready_q <= 1'b0;
         new_it_q   <= 1'b0;
         if ((state_q != IDLE) && final_i) begin
            final_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  y_q       <= in_y;
                  wire_a_q  <= in_A;
                  wire_ks_q <= in_Ks;
                  final_q   <= 1'b0;
                  new_it_q  <= 1'b1;
                  state_q   <= ISSUE;
               end else begin
                  // ready rises one cycle after entering IDLE
                  in_ready_q <= 1'b1;
               end
            end
            ISSUE: begin
               state_q <= WAIT_LOAD;
            end
            WAIT_LOAD: begin
               if (load) begin
                  state_q <= COLLECT;
               end else if (wdog_trip_s) begin
                  state_q <= IDLE;
               end
            end
            COLLECT: begin
               if (full_s) begin
                  state_q     <= HOLD;
                  est_valid_q <= 1'b1;
               end else if (wdog_trip_s) begin
                  state_q <= IDLE;
               end
            end
            HOLD: begin
               if (est_ready) begin
                  est_valid_q <= 1'b0;
                  est_count_q <= est_count_q + 32'd1;
                  if (final_seen_s) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            DONE: begin
               done_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign newIt     = new_it_q;
   assign y         = y_q;
   assign wireA     = wire_a_q;
   assign wireKs    = wire_ks_q;
   assign est_valid = est_valid_q;
   assign est_count = est_count_q;
   assign done      = done_q;

endmodule

// File: tb/tb_rls_driver.sv
// Self-checking bench for rls_driver (N=2, 32-bit words, TIMEOUT=16).
// A transaction-level model predicts every output each cycle; directed
// sequences add literal expectations at key points.
module tb_rls_driver;

   localparam int N  = 2;
   localparam int NB = 32;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [NB-1:0]   in_y = '0;
   logic [N*NB-1:0] in_A = '0;
   logic [N*NB-1:0] in_Ks = '0;
   logic            newIt;
   logic [NB-1:0]   y;
   logic [N*NB-1:0] wireA;
   logic [N*NB-1:0] wireKs;
   logic            load = 1'b0;
   logic            write = 1'b0;
   logic [NB-1:0]   x = '0;
   logic            final_i = 1'b0;
   logic            est_valid;
   logic            est_ready = 1'b0;
   logic [N*NB-1:0] est_x;
   logic [31:0]     est_count;
   logic            done;
   logic            wdog_err;

   int checks = 0;
   int errors = 0;

   rls_driver #(.N(N), .nBits(NB), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_y(in_y), .in_A(in_A), .in_Ks(in_Ks),
      .newIt(newIt), .y(y), .wireA(wireA), .wireKs(wireKs),
      .load(load), .write(write), .x(x), .final_i(final_i),
      .est_valid(est_valid), .est_ready(est_ready), .est_x(est_x),
      .est_count(est_count), .done(done), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int          cyc = 0;
   bit          m_busy, m_finished, m_loaded, m_fin, m_wdog;
   int          m_idle_age = 0;
   int          m_acc = -100;
   int          m_stall = 0;
   logic [31:0] m_count = '0;
   logic [31:0] m_words[$];
   logic [NB-1:0]   m_y = '0;
   logic [N*NB-1:0] m_A = '0;
   logic [N*NB-1:0] m_Ks = '0;

   task automatic model_step();
      bit fin_now;
      bit progress;
      cyc++;
      if (reset) begin
         m_busy = 0; m_finished = 0; m_loaded = 0; m_fin = 0; m_wdog = 0;
         m_idle_age = 0; m_acc = -100; m_stall = 0; m_count = '0;
         m_words.delete(); m_y = '0; m_A = '0; m_Ks = '0;
      end else if (!m_finished) begin
         if (!m_busy) begin
            if (m_idle_age >= 1 && in_valid) begin
               m_busy = 1; m_acc = cyc; m_loaded = 0; m_fin = 0; m_stall = 0;
               m_words.delete(); m_y = in_y; m_A = in_A; m_Ks = in_Ks;
            end else begin
               m_idle_age++;
            end
         end else begin
            fin_now = m_fin | final_i;
            if (m_words.size() == N) begin
               if (est_ready) begin
                  m_count = m_count + 32'd1;
                  m_busy = 0; m_idle_age = 0;
                  if (fin_now) m_finished = 1;
               end
            end else begin
               progress = 0;
               if (!m_loaded) begin
                  if (cyc >= m_acc + 2 && load) begin m_loaded = 1; progress = 1; end
               end else if (write) begin
                  m_words.push_back(x); progress = 1;
               end
`ifdef RLS_DRV_WDOG_EN
               if (cyc >= m_acc + 2 && m_words.size() < N) begin
                  if (progress) m_stall = 0;
                  else begin
                     m_stall++;
                     if (m_stall == TO) begin m_wdog = 1; m_busy = 0; m_idle_age = 0; end
                  end
               end
`endif
            end
            m_fin = fin_now;
         end
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(posedge clk) begin : cmp_proc
      logic [63:0] e;
      model_step();
      #1;
      chk("in_ready", in_ready, !m_busy && !m_finished && m_idle_age >= 1);
      chk("newIt", newIt, m_busy && cyc == m_acc);
      chk("y", y, m_y);
      chk("wireA", wireA, m_A);
      chk("wireKs", wireKs, m_Ks);
      chk("est_valid", est_valid, m_busy && m_words.size() == N);
      chk("est_count", est_count, m_count);
      chk("done", done, m_finished);
      chk("wdog_err", wdog_err, m_wdog);
      if (m_busy && m_words.size() == N) begin
         e = '0;
         for (int k = 0; k < N; k++) e[k*NB +: NB] = m_words[k];
         chk("est_x", est_x, e);
      end
   end

   // ---------------- stimulus helpers (called and return at a negedge) ----------------
   task automatic send_sample(input logic [31:0] yv, input logic [63:0] av, input logic [63:0] kv);
      int b = 0;
      in_valid = 1'b1; in_y = yv; in_A = av; in_Ks = kv;
      while (!in_ready && b < 40) begin @(negedge clk); b++; end
      chk("accept_wait", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] v);
      write = 1'b1; x = v;
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic consume(input int stall, input logic [63:0] exp);
      int b = 0;
      while (!est_valid && b < 40) begin @(negedge clk); b++; end
      chk("est_valid_wait", est_valid, 1'b1);
      chk("est_x_first", est_x, exp);
      for (int i = 0; i < stall; i++) begin
         chk("stall_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      chk("est_x_last", est_x, exp);
      est_ready = 1'b1;
      @(negedge clk);
      est_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_est_count", est_count, 32'd0);
      chk("rst_done", done, 1'b0);
      chk("rst_est_x", est_x, 64'd0);
      chk("rst_y", y, 32'd0);
      reset = 1'b0;

      // spurious strobes while idle
      write = 1'b1; x = 32'hDEAD;
      @(negedge clk); write = 1'b0; load = 1'b1;
      @(negedge clk); load = 1'b0;

      // iteration 1: load at t+3, words 0x11 then 0x22
      send_sample(32'd5, {32'd2, 32'd3}, {32'd1, 32'd1});
      chk("newit_t1", newIt, 1'b1);
      @(negedge clk);
      chk("newit_t2", newIt, 1'b0);
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
      do_write(32'h11);
      do_write(32'h22);
      consume(0, 64'h00000022_00000011);
      chk("count_1", est_count, 32'd1);

      // iteration 2: writes in ISSUE/WAIT_LOAD, write with load, third write, 10-cycle stall
      send_sample(32'd7, {32'd4, 32'd5}, {32'd6, 32'd7});
      write = 1'b1; x = 32'h99;
      @(negedge clk);
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0; x = 32'hA1;
      @(negedge clk); x = 32'hB2;
      @(negedge clk); x = 32'hC3;
      @(negedge clk); write = 1'b0;
      consume(10, 64'h000000B2_000000A1);
      chk("count_2", est_count, 32'd2);

      // iteration 3: final flagged while waiting for load
      send_sample(32'd8, {32'd9, 32'd10}, {32'd11, 32'd12});
      @(negedge clk); final_i = 1'b1; load = 1'b1;
      @(negedge clk); final_i = 1'b0; load = 1'b0;
      do_write(32'h5A);
      do_write(32'hA5);
      consume(2, 64'h000000A5_0000005A);
      chk("count_3", est_count, 32'd3);
      chk("done_set", done, 1'b1);
      chk("done_in_ready", in_ready, 1'b0);
      in_valid = 1'b1; in_y = 32'hBAD;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      chk("done_y_held", y, 32'd8);
      chk("done_count_held", est_count, 32'd3);

      // reset out of DONE, then abandon an iteration after its first word
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      send_sample(32'd9, {32'd1, 32'd2}, {32'd3, 32'd4});
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
      do_write(32'h55);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_newit", newIt, 1'b0);
      chk("mid_rst_valid", est_valid, 1'b0);
      chk("mid_rst_count", est_count, 32'd0);
      chk("mid_rst_y", y, 32'd0);
      chk("mid_rst_wireA", wireA, 64'd0);
      chk("mid_rst_est_x", est_x, 64'd0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      send_sample(32'd3, {32'd5, 32'd6}, {32'd7, 32'd8});
      @(negedge clk); load = 1'b1;
      @(negedge clk); load = 1'b0;
      do_write(32'h33);
      do_write(32'h44);
      consume(1, 64'h00000044_00000033);
      chk("count_after_rst", est_count, 32'd1);

`ifdef RLS_DRV_WDOG_EN
      // core never loads: watchdog trips after TO stalled cycles
      send_sample(32'd1, {32'd1, 32'd1}, {32'd1, 32'd1});
      repeat (18) @(negedge clk);
      chk("wdog_set", wdog_err, 1'b1);
      chk("wdog_count", est_count, 32'd1);
      chk("wdog_valid", est_valid, 1'b0);
      chk("wdog_idle", in_ready, 1'b1);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
